// File: rtl/noc_pkg.sv
// Shared NoC link definitions: flit type codes, type field width, default sizes.
// Used by noc_link_tx and noc_tx_skid; the optional LINK_PARITY_EN build adds no package content.
package noc_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_CREDIT_MAX = 8;
    localparam int NOC_CNT_W      = 4;

    // Flit type occupies the top FLIT_TYPE_W bits of each flit
    localparam int FLIT_TYPE_W    = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/noc_tx_skid.sv
// Two-entry skid buffer with bypass. When empty and the consumer is ready, the
// incoming flit goes straight through; otherwise it is queued in arrival order.
module noc_tx_skid
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            count_o
);

    logic [1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       push, pop;

    // Arriving data is only stored when it is not consumed through the bypass
    assign pop  = out_ready_i && (cnt_q != 2'd0);
    assign push = in_valid_i && !(out_ready_i && (cnt_q == 2'd0));

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop) begin
            mem_d[0] = mem_q[1];
            cnt_d    = cnt_d - 2'd1;
        end
        if (push) begin
            mem_d[cnt_d[0]] = in_data_i;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_data_o = (cnt_q != 2'd0) ? mem_q[0] : in_data_i;
    assign count_o    = cnt_q;

endmodule

// File: rtl/noc_link_tx.sv
// Router output link transmitter: FIFO drain, credit flow control, wormhole framing check.
// Define LINK_PARITY_EN to add a registered even-parity output alongside link_flit.
module noc_link_tx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int CREDIT_MAX = NOC_CREDIT_MAX,
    parameter int CNT_W      = NOC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_flit,
    input  logic                  credit_in,
    output logic [CNT_W-1:0]      credit_cnt,
    output logic                  pkt_active,
    output logic                  credit_err,
`ifdef LINK_PARITY_EN
    output logic                  link_parity,
`endif
    output logic                  proto_err
);

    localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_MAX);

    logic                  inflight_q;
    logic                  link_valid_q;
    logic [DATA_WIDTH-1:0] link_flit_q;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic                  credit_err_q, credit_err_d;
    logic                  proto_err_q, proto_err_d;
    tx_state_e             state_q, state_d;

    logic [1:0]            skid_cnt;
    logic [1:0]            occ, occ_left;
    logic                  send;
    logic [DATA_WIDTH-1:0] head_flit;
    flit_type_e            ftype;

    // Occupancy counts the read already issued to the FIFO, so the skid can never overflow
    assign occ        = skid_cnt + {1'b0, inflight_q};
    assign send       = (occ != 2'd0) && (credit_q != '0);
    assign occ_left   = occ - {1'b0, send};
    assign fifo_rd_en = !rst && !fifo_empty && (occ_left < 2'd2);

    noc_tx_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   (fifo_rd_data),
        .out_ready_i (send),
        .out_data_o  (head_flit),
        .count_o     (skid_cnt)
    );

    assign ftype = flit_type_e'(head_flit[DATA_WIDTH-1 -: FLIT_TYPE_W]);

    // A return arriving together with a send is a legal exchange even at the full count
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({credit_in, send})
            2'b10: begin
                if (credit_q == CREDIT_FULL) credit_err_d = 1'b1;
                else                         credit_d     = credit_q + 1'b1;
            end
            2'b01:   credit_d = credit_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        if (send) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (ftype)
                        FLIT_HEAD:   state_d = ST_PKT;
                        FLIT_SINGLE: state_d = ST_IDLE;
                        default:     proto_err_d = 1'b1;
                    endcase
                end
                ST_PKT: begin
                    unique case (ftype)
                        FLIT_BODY: state_d = ST_PKT;
                        FLIT_TAIL: state_d = ST_IDLE;
                        default:   proto_err_d = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            link_valid_q <= 1'b0;
            link_flit_q  <= '0;
            credit_q     <= CREDIT_FULL;
            credit_err_q <= 1'b0;
            proto_err_q  <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            inflight_q   <= fifo_rd_en;
            link_valid_q <= send;
            if (send) link_flit_q <= head_flit;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            proto_err_q  <= proto_err_d;
            state_q      <= state_d;
        end
    end

`ifdef LINK_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst)       parity_q <= 1'b0;
        else if (send) parity_q <= ^head_flit;
    end

    assign link_parity = parity_q;
`endif

    assign link_valid = link_valid_q;
    assign link_flit  = link_flit_q;
    assign credit_cnt = credit_q;
    assign pkt_active = (state_q == ST_PKT);
    assign credit_err = credit_err_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// Self-checking bench for noc_link_tx: FIFO model, flit scoreboard, framing vector table.
// Parity checks are compiled in when LINK_PARITY_EN is defined.
module tb_noc_link_tx;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          link_valid;
    logic [DW-1:0] link_flit;
    logic          credit_in = 1'b0;
    logic [3:0]    credit_cnt;
    logic          pkt_active;
    logic          credit_err;
    logic          proto_err;
`ifdef LINK_PARITY_EN
    logic          link_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    noc_link_tx dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .link_valid   (link_valid),
        .link_flit    (link_flit),
        .credit_in    (credit_in),
        .credit_cnt   (credit_cnt),
        .pkt_active   (pkt_active),
        .credit_err   (credit_err),
`ifdef LINK_PARITY_EN
        .link_parity  (link_parity),
`endif
        .proto_err    (proto_err)
    );

    // Upstream FIFO model: data appears the cycle after a pop; shares the reset
    logic [DW-1:0] fifo_mem [256];
    int            n_push = 0;
    int            n_pop  = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] sb_exp;

    assign fifo_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (rst) begin
            n_pop <= n_push;
        end else if (fifo_rd_en) begin
            n_cmp++;
            if (fifo_empty) begin
                n_err++;
                $display("FAIL pop_on_empty got rd_en=1 required rd_en=0");
            end else begin
                fifo_rd_data <= fifo_mem[n_pop % 256];
                n_pop        <= n_pop + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && link_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_flit got %h required no flit", link_flit);
            end else begin
                sb_exp = exp_q.pop_front();
                if (link_flit !== sb_exp) begin
                    n_err++;
                    $display("FAIL flit_order got %h required %h", link_flit, sb_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_now(input logic [DW-1:0] f);
        fifo_mem[n_push % 256] = f;
        exp_q.push_back(f);
        n_push = n_push + 1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (link_valid) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout got no link_valid required link_valid within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic credit_pulse();
        @(posedge clk);
        #1 credit_in = 1'b1;
        @(posedge clk);
        #1 credit_in = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] flit;
        logic          exp_pkt;
        logic          exp_perr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h4000_0010, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0011, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0012, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0013, 1'b0, 1'b0};
        vecs[4] = '{32'hC000_0014, 1'b0, 1'b0};
        vecs[5] = '{32'h4000_0020, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0021, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_link_valid", {31'b0, link_valid}, 32'd0);
        chk("rst_link_flit",  link_flit, 32'd0);
        chk("rst_credit_cnt", {28'b0, credit_cnt}, 32'd8);
        chk("rst_pkt_active", {31'b0, pkt_active}, 32'd0);
        chk("rst_errors",     {30'b0, credit_err, proto_err}, 32'd0);
        chk("rst_rd_en_idle", {31'b0, fifo_rd_en}, 32'd0);

        // First-flit latency: rd_en at t0, link_valid at t2
        push_now(32'h7000_00AA);
        #1 chk("lat_rd_en_t0", {31'b0, fifo_rd_en}, 32'd1);
        @(negedge clk);
        chk("lat_valid_t1", {31'b0, link_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid_t2", {31'b0, link_valid}, 32'd1);
        chk("lat_credit",   {28'b0, credit_cnt}, 32'd7);
        chk("lat_pkt_head", {31'b0, pkt_active}, 32'd1);
        @(negedge clk);
        push_now(32'h8000_00AB);
        wait_valid("lat_tail", 6);
        chk("lat_pkt_tail", {31'b0, pkt_active}, 32'd0);
        chk("lat_credit2",  {28'b0, credit_cnt}, 32'd6);
        credit_pulse();
        credit_pulse();
        @(negedge clk);
        chk("lat_credit_back", {28'b0, credit_cnt}, 32'd8);

        // Framing vector table, one flit per entry with its credit returned
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            push_now(vecs[v].flit);
            wait_valid($sformatf("vec%0d", v), 6);
            chk($sformatf("vec%0d_pkt", v),  {31'b0, pkt_active}, {31'b0, vecs[v].exp_pkt});
            chk($sformatf("vec%0d_perr", v), {31'b0, proto_err},  {31'b0, vecs[v].exp_perr});
            credit_pulse();
            @(negedge clk);
            chk($sformatf("vec%0d_credit", v), {28'b0, credit_cnt}, 32'd8);
        end

        // 9-flit packet with no returns: 8 back-to-back, then stall until one credit
        @(negedge clk);
        push_now(32'h4000_0100);
        for (int i = 1; i <= 7; i++) push_now(32'h0000_0100 + i);
        push_now(32'h8000_0108);
        wait_valid("burst_start", 6);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("burst_b2b%0d", i), {31'b0, link_valid}, 32'd1);
        end
        @(negedge clk);
        chk("burst_stall_valid",  {31'b0, link_valid}, 32'd0);
        chk("burst_stall_credit", {28'b0, credit_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        chk("burst_hold_valid", {31'b0, link_valid}, 32'd0);
        chk("burst_hold_pkt",   {31'b0, pkt_active}, 32'd1);
        credit_pulse();
        wait_valid("burst_tail", 4);
        chk("burst_tail_pkt",    {31'b0, pkt_active}, 32'd0);
        chk("burst_tail_credit", {28'b0, credit_cnt}, 32'd0);
        repeat (8) credit_pulse();
        @(negedge clk);
        chk("burst_credit_back", {28'b0, credit_cnt}, 32'd8);

        // Credit returned with every send: count pinned at 8, no bubbles
        @(negedge clk);
        push_now(32'h4000_0200);
        for (int i = 1; i <= 4; i++) push_now(32'h0000_0200 + i);
        push_now(32'h8000_0205);
        @(posedge clk);
        #1 credit_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("coin_t1_valid", {31'b0, link_valid}, 32'd0);
            else        chk($sformatf("coin_valid%0d", k), {31'b0, link_valid}, 32'd1);
            chk($sformatf("coin_credit%0d", k), {28'b0, credit_cnt}, 32'd8);
        end
        @(posedge clk);
        #1 credit_in = 1'b0;
        @(negedge clk);
        chk("coin_last_valid",  {31'b0, link_valid}, 32'd1);
        chk("coin_last_credit", {28'b0, credit_cnt}, 32'd8);
        @(negedge clk);
        chk("coin_done_valid", {31'b0, link_valid}, 32'd0);
        chk("coin_no_err",     {31'b0, credit_err}, 32'd0);

        // Credit overflow is sticky
        credit_pulse();
        @(negedge clk);
        chk("ovf_err",    {31'b0, credit_err}, 32'd1);
        chk("ovf_credit", {28'b0, credit_cnt}, 32'd8);

        // Framing violations: flits still go out, error sticks, state holds
        @(negedge clk);
        push_now(32'h0000_0055);
        wait_valid("perr_body", 6);
        chk("perr_body_err", {31'b0, proto_err},  32'd1);
        chk("perr_body_pkt", {31'b0, pkt_active}, 32'd0);
        credit_pulse();
        @(negedge clk);
        push_now(32'h4000_0060);
        wait_valid("perr_head", 6);
        chk("perr_head_pkt", {31'b0, pkt_active}, 32'd1);
        @(negedge clk);
        push_now(32'h4000_0061);
        wait_valid("perr_head2", 6);
        chk("perr_head2_pkt", {31'b0, pkt_active}, 32'd1);
        @(negedge clk);
        push_now(32'hC000_0062);
        wait_valid("perr_single", 6);
        chk("perr_single_pkt", {31'b0, pkt_active}, 32'd1);
        @(negedge clk);
        push_now(32'h8000_0063);
        wait_valid("perr_tail", 6);
        chk("perr_tail_pkt",   {31'b0, pkt_active}, 32'd0);
        chk("perr_sticky",     {31'b0, proto_err},  32'd1);
        chk("ovf_err_sticky",  {31'b0, credit_err}, 32'd1);
        repeat (4) credit_pulse();
        @(negedge clk);
        chk("perr_credit_back", {28'b0, credit_cnt}, 32'd8);

        // Reset mid-burst with a read in flight
        @(negedge clk);
        push_now(32'h4000_0300);
        for (int i = 1; i <= 4; i++) push_now(32'h0000_0300 + i);
        push_now(32'h8000_0305);
        wait_valid("mid_start", 6);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_valid",  {31'b0, link_valid}, 32'd0);
        chk("mid_flit",   link_flit, 32'd0);
        chk("mid_credit", {28'b0, credit_cnt}, 32'd8);
        chk("mid_pkt",    {31'b0, pkt_active}, 32'd0);
        chk("mid_errs",   {30'b0, credit_err, proto_err}, 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_quiet", {31'b0, link_valid}, 32'd0);

        // Traffic resumes after reset
        push_now(32'hC000_0077);
        wait_valid("post_rst", 6);
        chk("post_rst_pkt",  {31'b0, pkt_active}, 32'd0);
        chk("post_rst_perr", {31'b0, proto_err},  32'd0);

`ifdef LINK_PARITY_EN
        @(negedge clk);
        push_now(32'h0000_0003);
        wait_valid("par3", 6);
        chk("parity_0x3", {31'b0, link_parity}, 32'd0);
        @(negedge clk);
        push_now(32'h0000_0001);
        wait_valid("par1", 6);
        chk("parity_0x1", {31'b0, link_parity}, 32'd1);
`endif

        repeat (4) @(negedge clk);
        #1 chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
